issue_stream: RTL and testbench

Parametrised region scanner for the convolution datapath, replacing the single-cycle issue broadcast. On `start` it latches a region of a padded, channel-major image. It walks that region x-fastest, then y, then z, issuing reads to the image BRAM. It emits each pixel with its coordinates on a valid/ready stream, substituting zero for padding positions. It tolerates any fixed RAM read latency and downstream back-pressure without losing or duplicating beats.

---
 rtl/issue_pkg.sv | 23 ++
 rtl/issue_fifo.sv | 43 ++++
 rtl/issue_stream.sv | 196 +++++++++++++++++++
 tb/tb_issue_stream.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and configuration checks for the issue_stream region scanner.
package issue_pkg;

  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  // True when the requested region cannot be walked as described by its bounds.
  function automatic logic cfg_illegal(
    input logic [CFG_W-1:0] x_min, x_max, x_start, x_end, y_min, y_max
  );
    return (y_max < y_min) || (x_max < x_min) ||
           (x_start < x_min) || (x_start > x_max) ||
           (x_end < x_min) || (x_end > x_max) ||
           ((y_min == y_max) && (x_end < x_start));
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous output buffer holding issued beats; exposes its occupancy for credit accounting.
module issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/issue_stream.sv
// Region scanner: walks a padded channel-major region, reads the image RAM and streams
// each pixel with its coordinates, using credits so RAM data is never dropped.
module issue_stream
  import issue_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int COORD_W    = 8,
  parameter int Z_W        = 9,
  parameter int PAD_W      = 2,
  parameter int ADDR_W     = 16,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = READ_LAT + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] cfg_image_dim,
  input  logic [PAD_W-1:0]   cfg_padding,
  input  logic [COORD_W-1:0] cfg_x_min,
  input  logic [COORD_W-1:0] cfg_x_max,
  input  logic [COORD_W-1:0] cfg_x_start,
  input  logic [COORD_W-1:0] cfg_x_end,
  input  logic [COORD_W-1:0] cfg_y_min,
  input  logic [COORD_W-1:0] cfg_y_max,
  input  logic [Z_W-1:0]     cfg_z_max,
  output logic               ram_rd_en,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  input  logic [DATA_W-1:0]  ram_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [Z_W-1:0]     out_z,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);
  localparam int EXT_W = COORD_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_W-1:0]     z;
    logic [DATA_W-1:0]  data;
    logic               last;
  } beat_t;

  typedef struct packed {
    logic               valid;
    logic               pad;
    logic               last;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_W-1:0]     z;
  } slot_t;

  typedef struct packed {
    logic [COORD_W-1:0] dim, x_min, x_max, x_start, x_end, y_min, y_max;
    logic [PAD_W-1:0]   pad;
    logic [Z_W-1:0]     z_max;
    logic [ADDR_W-1:0]  dim2;
    logic [ADDR_W-1:0]  row0;
  } cfg_t;

  state_t             state, state_next;
  cfg_t               cfg_in, cfg_q, b;
  slot_t              pipe [READ_LAT+1];
  beat_t              push_beat, head;
  logic [CNT_W-1:0]   fifo_count;
  logic [COORD_W-1:0] cur_x, cur_y, pos_x, pos_y, row_end;
  logic [Z_W-1:0]     cur_z, pos_z;
  logic [ADDR_W-1:0]  cur_row, cur_chan, pos_row, pos_chan, pos_addr;
  logic               accept, legal, issue, pop, credit, pos_pad, pos_last;
  int                 inflight;

  // Products are only formed once per start; the walk itself advances by additions.
  always_comb begin
    cfg_in         = '0;
    cfg_in.dim     = cfg_image_dim;
    cfg_in.pad     = cfg_padding;
    cfg_in.x_min   = cfg_x_min;
    cfg_in.x_max   = cfg_x_max;
    cfg_in.x_start = cfg_x_start;
    cfg_in.x_end   = cfg_x_end;
    cfg_in.y_min   = cfg_y_min;
    cfg_in.y_max   = cfg_y_max;
    cfg_in.z_max   = cfg_z_max;
    cfg_in.dim2    = ADDR_W'(cfg_image_dim) * ADDR_W'(cfg_image_dim);
    cfg_in.row0    = (ADDR_W'(cfg_y_min) - ADDR_W'(cfg_padding)) * ADDR_W'(cfg_image_dim);
  end

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign legal  = !cfg_illegal(CFG_W'(cfg_x_min), CFG_W'(cfg_x_max), CFG_W'(cfg_x_start),
                               CFG_W'(cfg_x_end), CFG_W'(cfg_y_min), CFG_W'(cfg_y_max));

  // The first position is issued straight from the cfg inputs so the read leaves one cycle after start.
  assign b        = accept ? cfg_in : cfg_q;
  assign pos_x    = accept ? cfg_x_start : cur_x;
  assign pos_y    = accept ? cfg_y_min : cur_y;
  assign pos_z    = accept ? '0 : cur_z;
  assign pos_row  = accept ? cfg_in.row0 : cur_row;
  assign pos_chan = accept ? '0 : cur_chan;
  assign pos_addr = pos_chan + pos_row + ADDR_W'(pos_x) - ADDR_W'(b.pad);
  assign pos_pad  = (EXT_W'(pos_x) < EXT_W'(b.pad)) || (EXT_W'(pos_y) < EXT_W'(b.pad)) ||
                    (EXT_W'(pos_x) >= EXT_W'(b.dim) + EXT_W'(b.pad)) ||
                    (EXT_W'(pos_y) >= EXT_W'(b.dim) + EXT_W'(b.pad));
  assign pos_last = (pos_x == b.x_end) && (pos_y == b.y_max) && (pos_z == b.z_max);
  assign row_end  = (pos_y == b.y_max) ? b.x_end : b.x_max;

  assign pop = out_valid && out_ready;

  always_comb begin
    inflight = 0;
    for (int i = 0; i <= READ_LAT; i++) if (pipe[i].valid) inflight++;
  end

  // Everything in the pipe will land in the FIFO, so it is counted against free space now.
  assign credit = (int'(fifo_count) - (pop ? 1 : 0) + inflight) < FIFO_DEPTH;
  assign issue  = (accept && legal) || ((state == SCAN) && credit);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = !legal ? DONE : (pos_last ? DRAIN : SCAN);
      SCAN:       if (issue && pos_last) state_next = DRAIN;
      DRAIN:      if (pop && head.last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cfg_err     <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      for (int i = 0; i <= READ_LAT; i++) pipe[i] <= '0;
    end else begin
      state     <= state_next;
      ram_rd_en <= issue && !pos_pad;
      if (accept) cfg_err <= !legal;
      if (issue) ram_rd_addr <= pos_addr;
      pipe[0] <= '{valid: issue, pad: pos_pad, last: pos_last, x: pos_x, y: pos_y, z: pos_z};
      for (int i = 1; i <= READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Config and cursor are always loaded by the accepting start before they are used.
  always_ff @(posedge clk) begin
    if (accept) cfg_q <= cfg_in;
    if (issue) begin
      if (pos_x != row_end) begin
        cur_x <= pos_x + COORD_W'(1); cur_y <= pos_y; cur_z <= pos_z;
        cur_row <= pos_row; cur_chan <= pos_chan;
      end else if (pos_y != b.y_max) begin
        cur_x <= b.x_min; cur_y <= pos_y + COORD_W'(1); cur_z <= pos_z;
        cur_row <= pos_row + ADDR_W'(b.dim); cur_chan <= pos_chan;
      end else begin
        cur_x <= b.x_start; cur_y <= b.y_min; cur_z <= pos_z + Z_W'(1);
        cur_row <= b.row0; cur_chan <= pos_chan + b.dim2;
      end
    end
  end

  always_comb begin
    push_beat      = '0;
    push_beat.x    = pipe[READ_LAT].x;
    push_beat.y    = pipe[READ_LAT].y;
    push_beat.z    = pipe[READ_LAT].z;
    push_beat.data = pipe[READ_LAT].pad ? '0 : ram_rd_data;
    push_beat.last = pipe[READ_LAT].last;
  end

  issue_fifo #(.WIDTH($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe[READ_LAT].valid),
    .push_data (push_beat),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_x     = out_valid ? head.x : '0;
  assign out_y     = out_valid ? head.y : '0;
  assign out_z     = out_valid ? head.z : '0;
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid && head.last;
  assign busy      = (state == SCAN) || (state == DRAIN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_issue_stream.sv
// Scoreboard bench for issue_stream at READ_LAT=3: directed regions, random back-pressure,
// illegal configuration and reset during a scan.
module tb_issue_stream;
  localparam int DATA_W = 18, COORD_W = 8, Z_W = 9, PAD_W = 2, ADDR_W = 16;
  localparam int READ_LAT = 3, FIFO_DEPTH = READ_LAT + 2;

  logic clk = 0, rst = 0, start = 0, out_ready = 1;
  logic [COORD_W-1:0] cfg_image_dim = 0, cfg_x_min = 0, cfg_x_max = 0, cfg_x_start = 0;
  logic [COORD_W-1:0] cfg_x_end = 0, cfg_y_min = 0, cfg_y_max = 0;
  logic [PAD_W-1:0]   cfg_padding = 0;
  logic [Z_W-1:0]     cfg_z_max = 0;
  logic               ram_rd_en, out_valid, out_last, busy, done, cfg_err;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic [DATA_W-1:0]  ram_rd_data, out_data;
  logic [COORD_W-1:0] out_x, out_y;
  logic [Z_W-1:0]     out_z;

  always #5 clk = ~clk;

  issue_stream #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .Z_W(Z_W), .PAD_W(PAD_W),
    .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_image_dim(cfg_image_dim), .cfg_padding(cfg_padding),
    .cfg_x_min(cfg_x_min), .cfg_x_max(cfg_x_max), .cfg_x_start(cfg_x_start),
    .cfg_x_end(cfg_x_end), .cfg_y_min(cfg_y_min), .cfg_y_max(cfg_y_max),
    .cfg_z_max(cfg_z_max),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  // RAM model: fixed contents, data valid READ_LAT cycles after the strobe, junk otherwise.
  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {2'b10, a ^ 16'h5A3C};
  endfunction

  logic [DATA_W-1:0] ram_pipe [READ_LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= ram_rd_en ? ram_word(ram_rd_addr) : 18'h3FFFF;
    for (int i = 1; i < READ_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rd_data = ram_pipe[READ_LAT-1];

  typedef struct {
    logic [COORD_W-1:0] x, y;
    logic [Z_W-1:0]     z;
    logic [DATA_W-1:0]  data;
    logic               last;
  } exp_t;

  exp_t              beat_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int  total = 0, bad = 0;
  int  beats_seen = 0, reads_seen = 0, max_out = 0;
  bit  addr_chk = 1, inflight_chk = 0, rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int x, input int y, input int z, input bit p, input int a,
                          input bit last);
    exp_t e;
    e.x = COORD_W'(x); e.y = COORD_W'(y); e.z = Z_W'(z); e.last = last;
    e.data = p ? '0 : ram_word(ADDR_W'(a));
    beat_q.push_back(e);
    if (!p) addr_q.push_back(ADDR_W'(a));
  endtask

  task automatic gen_region(input int dim, input int pad, input int xmin, input int xmax,
                            input int xs, input int xe, input int ymin, input int ymax,
                            input int zmax);
    for (int z = 0; z <= zmax; z++)
      for (int y = ymin; y <= ymax; y++) begin
        int xa, xb;
        xa = (y == ymin) ? xs : xmin;
        xb = (y == ymax) ? xe : xmax;
        for (int x = xa; x <= xb; x++) begin
          bit p;
          p = (x < pad) || (y < pad) || (x >= dim + pad) || (y >= dim + pad);
          push_exp(x, y, z, p, z*dim*dim + (y-pad)*dim + (x-pad),
                   (x == xe) && (y == ymax) && (z == zmax));
        end
      end
  endtask

  // Monitor: reads against the address queue, beats against the beat queue, stall stability.
  logic [COORD_W+COORD_W+Z_W+DATA_W+1:0] held;
  bit stalled_prev = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      if (ram_rd_en) begin
        reads_seen++;
        if (addr_chk) begin
          if (addr_q.size() == 0) check("read_unexpected", ram_rd_en, 0);
          else check("rd_addr", ram_rd_addr, addr_q.pop_front());
        end
      end
      if (stalled_prev)
        check("stall_payload", {out_valid, out_x, out_y, out_z, out_data, out_last}, held);
      if (out_valid && out_ready) begin
        beats_seen++;
        if (beat_q.size() == 0) check("beat_unexpected", out_valid, 0);
        else begin
          e = beat_q.pop_front();
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("out_z", out_z, e.z);
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
      end
      if (inflight_chk && (reads_seen - beats_seen > max_out)) max_out = reads_seen - beats_seen;
      stalled_prev = out_valid && !out_ready;
      held = {out_valid, out_x, out_y, out_z, out_data, out_last};
    end else stalled_prev = 0;
  end

  always @(posedge clk) if (rand_ready) begin
    #1 out_ready = ($urandom_range(0, 99) < 30);
  end

  task automatic set_cfg(input int dim, input int pad, input int xmin, input int xmax,
                         input int xs, input int xe, input int ymin, input int ymax,
                         input int zmax);
    cfg_image_dim = COORD_W'(dim); cfg_padding = PAD_W'(pad);
    cfg_x_min = COORD_W'(xmin); cfg_x_max = COORD_W'(xmax);
    cfg_x_start = COORD_W'(xs); cfg_x_end = COORD_W'(xe);
    cfg_y_min = COORD_W'(ymin); cfg_y_max = COORD_W'(ymax); cfg_z_max = Z_W'(zmax);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    // Scramble the inputs to prove the configuration was latched.
    cfg_x_min = '1; cfg_x_max = '0; cfg_y_min = '1; cfg_image_dim = 8'd3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, ram_rd_en, 0);
    check({tag, "_rd_addr"}, ram_rd_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_payload"}, {out_x, out_y, out_z, out_data, out_last}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  task automatic run_scan(input string tag, input int n_exp, input bit chk_lat, input bit first_rd);
    beats_seen = 0; reads_seen = 0; max_out = 0;
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_done_cleared"}, done, 0);
        check({tag, "_cfg_err_cleared"}, cfg_err, 0);
        check({tag, "_first_read"}, ram_rd_en, first_rd);
      end
      if (chk_lat) check({tag, "_first_valid_latency"}, out_valid, (k == 5));
    end
    for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_beat_count"}, beats_seen, n_exp);
    check({tag, "_beats_left"}, beat_q.size(), 0);
    check({tag, "_reads_left"}, addr_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1;

    // Full padded 6x6 view of a 4x4 image: border beats are zero with no read.
    set_cfg(4, 1, 0, 5, 0, 5, 0, 5, 0);
    gen_region(4, 1, 0, 5, 0, 5, 0, 5, 0);
    run_scan("padded", 36, 1, 0);

    // Single-row rectangle over three channels, hand-computed addresses.
    set_cfg(8, 0, 1, 3, 1, 3, 2, 2, 2);
    begin
      int a2 [9] = '{17, 18, 19, 81, 82, 83, 145, 146, 147};
      for (int i = 0; i < 9; i++) push_exp(1 + i % 3, 2, i / 3, 0, a2[i], i == 8);
    end
    run_scan("rect", 9, 1, 1);

    // Wrapping region: tail of row 1 then head of row 2.
    set_cfg(8, 0, 0, 7, 5, 2, 1, 2, 0);
    begin
      int xs3 [6] = '{5, 6, 7, 0, 1, 2};
      int ys3 [6] = '{1, 1, 1, 2, 2, 2};
      int a3  [6] = '{13, 14, 15, 16, 17, 18};
      for (int i = 0; i < 6; i++) push_exp(xs3[i], ys3[i], 0, 0, a3[i], i == 5);
    end
    run_scan("wrap", 6, 1, 1);

    // Illegal: single row with x_end before x_start.
    set_cfg(8, 0, 0, 7, 3, 1, 2, 2, 0);
    pulse_start();
    @(negedge clk);
    check("illegal_cfg_err", cfg_err, 1);
    check("illegal_done", done, 1);
    check("illegal_busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("illegal_no_read", ram_rd_en, 0);
      check("illegal_no_beat", out_valid, 0);
    end

    // 200 beats under random back-pressure.
    set_cfg(10, 0, 0, 9, 0, 9, 0, 9, 1);
    gen_region(10, 0, 0, 9, 0, 9, 0, 9, 1);
    rand_ready = 1; inflight_chk = 1;
    run_scan("backpressure", 200, 0, 1);
    check("backpressure_outstanding_le_depth", (max_out > FIFO_DEPTH), 0);
    rand_ready = 0; inflight_chk = 0;
    @(posedge clk); #2 out_ready = 1;

    // Reset with two reads in flight; late RAM data must not produce beats.
    addr_chk = 0;
    set_cfg(8, 0, 0, 7, 0, 7, 0, 7, 3);
    pulse_start();
    @(posedge clk); #1 rst = 0;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1 rst = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midreset_no_beat", out_valid, 0);
      check("midreset_no_read", ram_rd_en, 0);
    end
    addr_chk = 1;

    // Recovery after reset.
    set_cfg(8, 0, 1, 3, 1, 3, 2, 2, 2);
    begin
      int a2 [9] = '{17, 18, 19, 81, 82, 83, 145, 146, 147};
      for (int i = 0; i < 9; i++) push_exp(1 + i % 3, 2, i / 3, 0, a2[i], i == 8);
    end
    run_scan("recover", 9, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
